// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// EX-stage execution unit for the multicycle datapath. Decodes the main
// control ALU class (alu_op) together with the R-type funct field and
// executes the selected operation. Single-cycle operations complete with a
// registered one-cycle latency. MULTU (shift-add) and DIVU (restoring) are
// iterative: one bit per cycle for WIDTH cycles, writing the HI/LO pair.
//
// Optional feature macro: ALU_DIV_EN
//   defined   -> DIV state and restoring divider are built; DIVU executes.
//   undefined -> no divider logic; DIVU decodes as an illegal funct.
//
// Parameters
//   WIDTH    operand/result/HI/LO width (>= 8, even)
//   SHAMT_W  shift-amount width (2**SHAMT_W >= WIDTH)
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    launch request, sampled only while ready=1
//   alu_op   ALU class from main control
//   funct    R-type function field (used only when alu_op=000)
//   shamt    shift amount for SLL/SRL/SRA
//   a, b     operands
//   ready    high while IDLE
//   valid    one-cycle completion pulse
//   result   registered result, held until the next valid
//   zero     result == 0, updated with valid
//   ovf      signed overflow of ADD/SUB style operations
//   illegal  unsupported funct, updated with valid
//   hi, lo   HI/LO registers
//
// Handshake: ready is a pure decode of the registered state (IDLE). A start
// seen with ready=1 at a rising edge launches exactly one operation; start
// while ready=0 is dropped. valid is a pure decode of the DONE state, so it
// is high for exactly one cycle per accepted operation, and result, zero,
// ovf, illegal, hi and lo are already final while valid is high. There is
// no combinational path from start to ready or valid.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // Internal operation kind after class/funct decode. K_SLTI is the
    // class-decoded signed compare, which also reports subtract overflow.
    typedef enum logic [4:0] {
        K_ADD,
        K_ADDU,
        K_SUB,
        K_SUBU,
        K_AND,
        K_OR,
        K_XOR,
        K_NOR,
        K_SLT,
        K_SLTI,
        K_SLTU,
        K_SLL,
        K_SRL,
        K_SRA,
        K_MFHI,
        K_MFLO,
        K_MULTU,
        K_DIVU,
        K_ILLEGAL
    } kind_t;

    state_t state;
    state_t state_next;
    kind_t  kind;

    logic [CNT_W-1:0] cnt;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    always_comb begin
        kind = K_ILLEGAL;
        case (alu_op)
            3'b000: begin
                case (funct)
                    6'h20:   kind = K_ADD;
                    6'h21:   kind = K_ADDU;
                    6'h22:   kind = K_SUB;
                    6'h23:   kind = K_SUBU;
                    6'h24:   kind = K_AND;
                    6'h25:   kind = K_OR;
                    6'h26:   kind = K_XOR;
                    6'h27:   kind = K_NOR;
                    6'h2A:   kind = K_SLT;
                    6'h2B:   kind = K_SLTU;
                    6'h00:   kind = K_SLL;
                    6'h02:   kind = K_SRL;
                    6'h03:   kind = K_SRA;
                    6'h10:   kind = K_MFHI;
                    6'h12:   kind = K_MFLO;
                    6'h19:   kind = K_MULTU;
`ifdef ALU_DIV_EN
                    6'h1B:   kind = K_DIVU;
`endif
                    default: kind = K_ILLEGAL;
                endcase
            end
            3'b001, 3'b010: kind = K_ADD;
            3'b011, 3'b100: kind = K_SUB;
            3'b101:         kind = K_OR;
            3'b110:         kind = K_AND;
            3'b111:         kind = K_SLTI;
            default:        kind = K_ILLEGAL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Single-cycle execute
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic signed [WIDTH-1:0] sra_val;
    logic                    add_ovf;
    logic                    sub_ovf;
    logic                    lt_s;
    logic                    lt_u;
    logic                    shamt_big;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;
    logic                    alu_illegal;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        // Signed overflow: operands agree (add) or differ (sub) in sign and
        // the result sign disagrees with a.
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        lt_s    = $signed(a) < $signed(b);
        lt_u    = a < b;
        // Kept in its own signed assignment so the shift stays arithmetic.
        sra_val = $signed(a) >>> shamt;
        // Only reachable when 2**SHAMT_W > WIDTH.
        shamt_big = {1'b0, shamt} >= (SHAMT_W + 1)'(WIDTH);

        alu_res     = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (kind)
            K_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            K_ADDU:  alu_res = sum;
            K_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            K_SUBU:  alu_res = diff;
            K_AND:   alu_res = a & b;
            K_OR:    alu_res = a | b;
            K_XOR:   alu_res = a ^ b;
            K_NOR:   alu_res = ~(a | b);
            K_SLT:   alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            K_SLTI: begin
                alu_res = {{(WIDTH-1){1'b0}}, lt_s};
                alu_ovf = sub_ovf;
            end
            K_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            K_SLL:   alu_res = shamt_big ? '0 : (a << shamt);
            K_SRL:   alu_res = shamt_big ? '0 : (a >> shamt);
            K_SRA:   alu_res = shamt_big ? {WIDTH{a[WIDTH-1]}} : sra_val;
            K_MFHI:  alu_res = hi;
            K_MFLO:  alu_res = lo;
            // Multi-cycle kinds produce their result from the iterative units.
            K_MULTU: alu_res = '0;
            K_DIVU:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift-add multiplier: prod holds {partial_hi, remaining_multiplier}.
    // Each step adds the multiplicand into the upper half when the current
    // multiplier LSB is set, then shifts the whole pair right by one.
    // -----------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     mul_sum;

    always_comb begin
        mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (prod[0]) begin
            prod_next = {mul_sum, prod[WIDTH-1:1]};
        end else begin
            prod_next = {1'b0, prod[2*WIDTH-1:1]};
        end
    end

`ifdef ALU_DIV_EN
    // -----------------------------------------------------------------------
    // Restoring divider: the dividend shifts out of quo MSB-first into rem
    // while quotient bits shift into quo's LSB. A zero divisor needs no
    // special case: every trial subtract succeeds, giving an all-ones
    // quotient and a remainder equal to the dividend.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (kind == K_MULTU) begin
                        state_next = S_MUL;
`ifdef ALU_DIV_EN
                    end else if (kind == K_DIVU) begin
                        state_next = S_DIV;
`endif
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        ready = (state == S_IDLE);
        valid = (state == S_DONE);
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            prod    <= '0;
            mcand   <= '0;
            cnt     <= '0;
`ifdef ALU_DIV_EN
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        case (kind)
                            K_MULTU: begin
                                prod  <= {{WIDTH{1'b0}}, b};
                                mcand <= a;
                            end
`ifdef ALU_DIV_EN
                            K_DIVU: begin
                                quo  <= a;
                                rem  <= '0;
                                dvsr <= b;
                            end
`endif
                            default: begin
                                result  <= alu_res;
                                zero    <= (alu_res == '0);
                                ovf     <= alu_ovf;
                                illegal <= alu_illegal;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        hi      <= prod_next[2*WIDTH-1:WIDTH];
                        lo      <= prod_next[WIDTH-1:0];
                        result  <= prod_next[WIDTH-1:0];
                        zero    <= (prod_next[WIDTH-1:0] == '0);
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
`ifdef ALU_DIV_EN
                S_DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        hi      <= rem_next;
                        lo      <= quo_next;
                        result  <= quo_next;
                        zero    <= (quo_next == '0);
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, clocked successor to the single-cycle ALU control decoder. It decodes the main-control ALU class plus the R-type funct field and executes the operation. Single-cycle ops finish with a registered 1-cycle latency; unsigned multiply and divide run as iterative multi-cycle ops into HI/LO. It sits in the EX stage of the multicycle datapath and talks to the control FSM through a start/ready/valid handshake.

## Interface
- WIDTH, 32: operand, result and HI/LO width; must be ≥ 8 and even.
- SHAMT_W, 5: shift-amount width; must satisfy 2^SHAMT_W ≥ WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  launch request; sampled only when ready=1.
- alu_op  in  3  class from main control: 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 BNE, 101 ORI, 110 ANDI, 111 SLTI.
- funct  in  6  R-type function field; ignored unless alu_op=000.
- shamt  in  SHAMT_W  shift amount for SLL/SRL/SRA.
- a, b  in  WIDTH  operands (rs, rt or immediate).
- ready  out  1  high in IDLE.
- valid  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result; held until the next valid.
- zero  out  1  (result == 0); updated with valid.
- ovf  out  1  signed overflow for ADD/SUB, else 0.
- illegal  out  1  unsupported funct/op; updated with valid.
- hi, lo  out  WIDTH  HI/LO registers.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; ready=1.
  - valid, result, zero, ovf, illegal, hi, lo all 0.
- IDLE with start=1, single-cycle op: result computed and registered; state→DONE.
- DONE: valid=1 for exactly one cycle; state→IDLE.
- Class decode, alu_op≠000:
  - 001/010 → ADD.
  - 011/100 → SUB.
  - 101 → OR.
  - 110 → AND.
  - 111 → SLT, signed.
- R-type funct codes (hex):
  - 20 ADD, 21 ADDU, 22 SUB, 23 SUBU.
  - 24 AND, 25 OR, 26 XOR, 27 NOR.
  - 2A SLT (signed), 2B SLTU.
  - 00 SLL, 02 SRL, 03 SRA; all by shamt.
  - 10 MFHI, 12 MFLO.
  - 19 MULTU, 1B DIVU.
- Arithmetic rules:
  - Results wrap modulo 2^WIDTH.
  - ovf is set only for ADD/SUB and class-decoded ADD/SUB/SLT paths, when signed overflow occurs.
  - SLT/SLTU write 0 or 1, zero-extended.
  - Shift amounts ≥ WIDTH give 0 for SLL/SRL and sign-fill for SRA.
- Any other funct: illegal=1, result=0; hi and lo unchanged; valid still pulses.
- MULTU (IDLE→MUL): shift-add, one bit per cycle for WIDTH cycles. Writes {hi,lo} = a·b (2·WIDTH bits), then →DONE with result=lo.
- DIVU (IDLE→DIV): restoring division, one quotient bit per cycle for WIDTH cycles. Writes lo=a/b, hi=a%b, then →DONE with result=lo.
- Divide by zero: lo=all ones, hi=a, illegal=0.
- Operands are captured at start; a and b may change freely while busy.
- start while ready=0 is ignored; it is neither queued nor errored.
- hi and lo change only at MULTU/DIVU completion or reset.

## Timing
- Single-cycle op: start accepted at edge N; valid=1 during cycle N+1; ready=1 again at N+2.
- MULTU/DIVU: valid in cycle N+WIDTH+1; ready=0 from N+1 through N+WIDTH+1.
- MFHI/MFLO issued immediately after a MULTU/DIVU valid return the new hi/lo.
- ready is a registered state decode; no combinational path from start to ready or valid.
- Synchronous reset mid-MUL/DIV:
  - Aborts the operation: no valid, partial products discarded.
  - hi and lo cleared; IDLE on the next cycle.

## Configuration
- ALU_DIV_EN defined: DIV state and the restoring divider are compiled in; DIVU behaves as above.
- ALU_DIV_EN undefined: no divider logic; DIVU is treated as an illegal funct (1-cycle, illegal=1, result=0, hi/lo unchanged).

## Test plan
- Reset, then R-type funct 20 with a=0x7FFFFFFF, b=1 → valid one cycle later, result=0x80000000, ovf=1, zero=0.
- alu_op=100 (BNE), a=b=0x1234 → result=0, zero=1, ovf=0; alu_op=111, a=0xFFFFFFFF, b=0 → result=1.
- MULTU a=0xFFFFFFFF, b=2; pulse start again mid-op → exactly one valid, at cycle 33; hi=1, lo=0xFFFFFFFE; then MFHI → result=1.
- DIVU a=100, b=7 → lo=14, hi=2. DIVU b=0 → lo=0xFFFFFFFF, hi=100. Without ALU_DIV_EN → illegal=1 after 1 cycle.
- funct 3F → illegal=1, result=0, hi/lo unchanged; SRA a=0x80000000, shamt=31 → 0xFFFFFFFF.
- rst_n=0 at cycle 10 of MULTU → no valid; ready=1, hi=lo=0 on the cycle after reset releases.
